// File: rtl/mem_pkg.sv
// Shared types and helpers for the LEGv8 memory stage: FSM state encoding,
// doubleword alignment mask and the wait-counter width rule.
package mem_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    // Doubleword accesses must have the low three address bits clear.
    localparam logic [2:0] ALIGN_MASK = 3'b111;

    localparam int MAX_WAIT_DEF = 16;

    // Counter must be able to hold MAX_WAIT itself (it steps once past the
    // last wait cycle on the abort edge before being cleared in IDLE).
    function automatic int wait_cnt_w(input int max_wait);
        return $clog2(max_wait + 1);
    endfunction

    function automatic logic is_aligned(input logic [2:0] addr_lo);
        return ((addr_lo & ALIGN_MASK) == 3'b000);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Ack-wait counter: cleared while the stage is idle, advanced on every
// access cycle without an ack, and flags the final permitted wait cycle.
module mem_wait_timer #(
    parameter int CW    = 5,
    parameter int LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear has priority over enable, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CW{1'b0}};
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/memory_stage.sv
// LEGv8 memory stage: resolves branches, runs data-memory loads/stores over
// a req/ack handshake with timeout, and registers results toward writeback.
module memory_stage #(
    parameter int DW       = 64,
    parameter int MAX_WAIT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic          MemRead_M,
    input  logic          MemWrite_M,
    input  logic          Branch_M,
    input  logic [DW-1:0] aluResult_M,
    input  logic [DW-1:0] writeData_M,
    input  logic          zero_M,
    input  logic [DW-1:0] PCBranch_M,
    output logic          stall,
    output logic          PCSrc_M,
    output logic [DW-1:0] PCBranch_out,
    output logic          dm_req,
    output logic          dm_we,
    output logic [DW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    input  logic          dm_ack,
    input  logic [DW-1:0] dm_rdata,
    output logic          out_valid,
    output logic [DW-1:0] readData_W,
    output logic [DW-1:0] aluResult_W,
    output logic          misalign_W,
    output logic          bus_err_W
);
    import mem_pkg::*;

    localparam int CW = wait_cnt_w(MAX_WAIT);

    state_e        state_q;
    logic          dm_req_q;
    logic          dm_we_q;
    logic [DW-1:0] dm_addr_q;
    logic [DW-1:0] dm_wdata_q;
    logic          out_valid_q;
    logic [DW-1:0] read_data_q;
    logic [DW-1:0] alu_result_q;
    logic          misalign_q;
    logic          bus_err_q;

    logic memop_s;
    logic aligned_s;
    logic issue_s;
    logic expire_s;
    logic in_access_s;

    assign memop_s     = MemRead_M | MemWrite_M;
    assign aligned_s   = is_aligned(aluResult_M[2:0]);
    assign in_access_s = (state_q == ACCESS);
    assign issue_s     = ~in_access_s & in_valid & memop_s & aligned_s;

    mem_wait_timer #(
        .CW    (CW),
        .LIMIT (MAX_WAIT)
    ) u_wait_timer (
        .clk_i    (clk),
        .rst_ni   (reset),
        .clr_i    (~in_access_s),
        .en_i     (in_access_s & ~dm_ack),
        .expire_o (expire_s)
    );

    // Upstream hold: while issuing an aligned access, then until ack or the last wait cycle.
    always_comb begin
        stall = 1'b0;
        if (in_access_s) begin
            stall = ~dm_ack & ~expire_s;
        end else begin
            stall = issue_s;
        end
    end

    // Branches only resolve when the stage is idle and the inputs are live.
    assign PCSrc_M      = in_valid & Branch_M & zero_M & ~in_access_s;
    assign PCBranch_out = PCBranch_M;

    // Access FSM with request and writeback registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            dm_req_q     <= 1'b0;
            dm_we_q      <= 1'b0;
            dm_addr_q    <= {DW{1'b0}};
            dm_wdata_q   <= {DW{1'b0}};
            out_valid_q  <= 1'b0;
            read_data_q  <= {DW{1'b0}};
            alu_result_q <= {DW{1'b0}};
            misalign_q   <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue_s) begin
                        state_q     <= ACCESS;
                        dm_req_q    <= 1'b1;
                        dm_we_q     <= MemWrite_M;
                        dm_addr_q   <= aluResult_M;
                        dm_wdata_q  <= writeData_M;
                        out_valid_q <= 1'b0;
                        misalign_q  <= 1'b0;
                        bus_err_q   <= 1'b0;
                    end else if (in_valid) begin
                        // ALU-only op, or a memory op skipped for misalignment.
                        out_valid_q  <= 1'b1;
                        alu_result_q <= aluResult_M;
                        read_data_q  <= {DW{1'b0}};
                        misalign_q   <= memop_s;
                        bus_err_q    <= 1'b0;
                    end else begin
                        out_valid_q <= 1'b0;
                        misalign_q  <= 1'b0;
                        bus_err_q   <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (dm_ack) begin
                        state_q      <= IDLE;
                        dm_req_q     <= 1'b0;
                        dm_we_q      <= 1'b0;
                        out_valid_q  <= 1'b1;
                        alu_result_q <= dm_addr_q;
                        read_data_q  <= dm_we_q ? {DW{1'b0}} : dm_rdata;
                        misalign_q   <= 1'b0;
                        bus_err_q    <= 1'b0;
                    end else if (expire_s) begin
                        state_q      <= IDLE;
                        dm_req_q     <= 1'b0;
                        dm_we_q      <= 1'b0;
                        out_valid_q  <= 1'b1;
                        alu_result_q <= dm_addr_q;
                        read_data_q  <= {DW{1'b0}};
                        misalign_q   <= 1'b0;
                        bus_err_q    <= 1'b1;
                    end else begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    dm_req_q    <= 1'b0;
                    dm_we_q     <= 1'b0;
                    out_valid_q <= 1'b0;
                    misalign_q  <= 1'b0;
                    bus_err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign dm_req      = dm_req_q;
    assign dm_we       = dm_we_q;
    assign dm_addr     = dm_addr_q;
    assign dm_wdata    = dm_wdata_q;
    assign out_valid   = out_valid_q;
    assign readData_W  = read_data_q;
    assign aluResult_W = alu_result_q;
    assign misalign_W  = misalign_q;
    assign bus_err_W   = bus_err_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: expected writeback records are queued
// when an instruction is driven and compared when out_valid pulses.
module tb_memory_stage;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, MemRead_M, MemWrite_M, Branch_M, zero_M;
    logic [DW-1:0] aluResult_M, writeData_M, PCBranch_M;
    logic          stall, PCSrc_M;
    logic [DW-1:0] PCBranch_out;
    logic          dm_req, dm_we, dm_ack;
    logic [DW-1:0] dm_addr, dm_wdata, dm_rdata;
    logic          out_valid, misalign_W, bus_err_W;
    logic [DW-1:0] readData_W, aluResult_W;

    typedef struct packed {
        logic [DW-1:0] alu;
        logic [DW-1:0] rd;
        logic          mis;
        logic          berr;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    memory_stage #(.DW(DW), .MAX_WAIT(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M), .Branch_M(Branch_M),
        .aluResult_M(aluResult_M), .writeData_M(writeData_M), .zero_M(zero_M),
        .PCBranch_M(PCBranch_M), .stall(stall), .PCSrc_M(PCSrc_M),
        .PCBranch_out(PCBranch_out), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
        .dm_rdata(dm_rdata), .out_valid(out_valid), .readData_W(readData_W),
        .aluResult_W(aluResult_W), .misalign_W(misalign_W), .bus_err_W(bus_err_W)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 1'b0; MemRead_M = 1'b0; MemWrite_M = 1'b0; Branch_M = 1'b0;
        zero_M = 1'b0; aluResult_M = 64'h0; writeData_M = 64'h0; PCBranch_M = 64'h0;
    endtask

    // Drives one memory instruction and plays the memory side; acks in the
    // ack_at-th request cycle (0 = never). Returns at the out_valid cycle.
    task automatic do_access(input logic we, input logic [DW-1:0] addr,
                             input logic [DW-1:0] wdata, input int ack_at,
                             input logic [DW-1:0] rdata,
                             output int req_cycles, output int stall_cycles,
                             output logic ok, output logic stable,
                             output logic last_stall, output logic f_we,
                             output logic [DW-1:0] f_addr, output logic [DW-1:0] f_wdata);
        req_cycles = 0; stall_cycles = 0; ok = 1'b0; stable = 1'b1; last_stall = 1'b1;
        f_we = 1'b0; f_addr = 64'h0; f_wdata = 64'h0;
        in_valid = 1'b1; MemRead_M = ~we; MemWrite_M = we;
        aluResult_M = addr; writeData_M = wdata;
        #1;
        if (stall) stall_cycles++;
        for (int i = 0; i < 64; i++) begin
            tick();
            dm_ack = 1'b0;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            if (dm_req) begin
                req_cycles++;
                if (req_cycles == 1) begin
                    f_addr = dm_addr; f_we = dm_we; f_wdata = dm_wdata;
                end else if (dm_addr !== f_addr || dm_we !== f_we || dm_wdata !== f_wdata) begin
                    stable = 1'b0;
                end
            end
            if (ack_at != 0 && req_cycles == ack_at) begin
                dm_ack = 1'b1; dm_rdata = rdata;
            end
            // Garbage on the M inputs while ACCESS must be ignored.
            aluResult_M = 64'hBAD0_BAD0_BAD0_BAD7; writeData_M = 64'hFFFF_FFFF_FFFF_FFFF;
            #1;
            last_stall = stall;
            if (stall) stall_cycles++;
        end
        clear_inputs();
    endtask

    task automatic test_reset();
        total++;
        if ({dm_req, dm_we, out_valid, misalign_W, bus_err_W, stall} !== 6'b0 ||
            dm_addr !== 64'h0 || dm_wdata !== 64'h0 || readData_W !== 64'h0 || aluResult_W !== 64'h0) begin
            bad++;
            $display("FAIL reset_state: req=%b we=%b ov=%b mis=%b berr=%b stall=%b addr=%h wd=%h rd=%h alu=%h, want all zero",
                     dm_req, dm_we, out_valid, misalign_W, bus_err_W, stall, dm_addr, dm_wdata, readData_W, aluResult_W);
        end
    endtask

    task automatic test_alu_only();
        exp_t e;
        in_valid = 1'b1; aluResult_M = 64'h40;
        sb.push_back('{alu: 64'h40, rd: 64'h0, mis: 1'b0, berr: 1'b0});
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL alu_stall: got %b want 0", stall); end
        tick();
        clear_inputs();
        total++;
        if (out_valid !== 1'b1 || stall !== 1'b0) begin
            bad++; $display("FAIL alu_ov: ov=%b stall=%b want ov=1 stall=0", out_valid, stall);
        end
        e = sb.pop_front();
        total++;
        if ({aluResult_W, readData_W, misalign_W, bus_err_W} !== e) begin
            bad++; $display("FAIL alu_wb: got alu=%h rd=%h mis=%b berr=%b want alu=%h rd=%h mis=%b berr=%b",
                            aluResult_W, readData_W, misalign_W, bus_err_W, e.alu, e.rd, e.mis, e.berr);
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL alu_pulse: ov=%b want 0", out_valid); end
    endtask

    task automatic test_load();
        exp_t e; int rq, st; logic ok, stb, ls, fwe; logic [DW-1:0] fa, fw;
        sb.push_back('{alu: 64'h100, rd: 64'hDEADBEEF, mis: 1'b0, berr: 1'b0});
        do_access(1'b0, 64'h100, 64'h0, 3, 64'hDEADBEEF, rq, st, ok, stb, ls, fwe, fa, fw);
        total++;
        if (!ok) begin bad++; $display("FAIL load_timeout: no out_valid within bound"); end
        total++;
        if (rq != 3 || st != 3 || ls !== 1'b0 || stb !== 1'b1 || fa !== 64'h100 || fwe !== 1'b0) begin
            bad++; $display("FAIL load_req: req_cyc=%0d stall_cyc=%0d ack_stall=%b stable=%b addr=%h we=%b want 3 3 0 1 100 0",
                            rq, st, ls, stb, fa, fwe);
        end
        e = sb.pop_front();
        total++;
        if ({aluResult_W, readData_W, misalign_W, bus_err_W} !== e || dm_req !== 1'b0) begin
            bad++; $display("FAIL load_wb: got alu=%h rd=%h mis=%b berr=%b req=%b want alu=%h rd=%h mis=%b berr=%b req=0",
                            aluResult_W, readData_W, misalign_W, bus_err_W, dm_req, e.alu, e.rd, e.mis, e.berr);
        end
        tick();
    endtask

    task automatic test_store();
        exp_t e; int rq, st; logic ok, stb, ls, fwe; logic [DW-1:0] fa, fw;
        sb.push_back('{alu: 64'h8, rd: 64'h0, mis: 1'b0, berr: 1'b0});
        do_access(1'b1, 64'h8, 64'h1234, 1, 64'hFFFF_0000_AAAA_5555, rq, st, ok, stb, ls, fwe, fa, fw);
        total++;
        if (!ok || rq != 1 || st != 1 || ls !== 1'b0 || fwe !== 1'b1 || fw !== 64'h1234 || fa !== 64'h8) begin
            bad++; $display("FAIL store_req: ok=%b req_cyc=%0d stall_cyc=%0d ack_stall=%b we=%b wdata=%h addr=%h want 1 1 1 0 1 1234 8",
                            ok, rq, st, ls, fwe, fw, fa);
        end
        e = sb.pop_front();
        total++;
        if ({aluResult_W, readData_W, misalign_W, bus_err_W} !== e) begin
            bad++; $display("FAIL store_wb: got alu=%h rd=%h mis=%b berr=%b want alu=%h rd=%h mis=%b berr=%b",
                            aluResult_W, readData_W, misalign_W, bus_err_W, e.alu, e.rd, e.mis, e.berr);
        end
        tick();
    endtask

    task automatic test_misaligned();
        exp_t e;
        in_valid = 1'b1; MemRead_M = 1'b1; aluResult_M = 64'h103;
        sb.push_back('{alu: 64'h103, rd: 64'h0, mis: 1'b1, berr: 1'b0});
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL misalign_stall: got %b want 0", stall); end
        tick();
        clear_inputs();
        total++;
        if (dm_req !== 1'b0 || out_valid !== 1'b1) begin
            bad++; $display("FAIL misalign_ov: req=%b ov=%b want req=0 ov=1", dm_req, out_valid);
        end
        e = sb.pop_front();
        total++;
        if ({aluResult_W, readData_W, misalign_W, bus_err_W} !== e) begin
            bad++; $display("FAIL misalign_wb: got alu=%h rd=%h mis=%b berr=%b want alu=%h rd=%h mis=%b berr=%b",
                            aluResult_W, readData_W, misalign_W, bus_err_W, e.alu, e.rd, e.mis, e.berr);
        end
        tick();
    endtask

    task automatic test_timeout();
        exp_t e; int rq, st; logic ok, stb, ls, fwe; logic [DW-1:0] fa, fw;
        sb.push_back('{alu: 64'h2000, rd: 64'h0, mis: 1'b0, berr: 1'b1});
        do_access(1'b0, 64'h2000, 64'h0, 0, 64'h0, rq, st, ok, stb, ls, fwe, fa, fw);
        total++;
        if (!ok || rq != 16 || st != 16 || ls !== 1'b0 || stb !== 1'b1) begin
            bad++; $display("FAIL timeout_req: ok=%b req_cyc=%0d stall_cyc=%0d last_stall=%b stable=%b want 1 16 16 0 1",
                            ok, rq, st, ls, stb);
        end
        e = sb.pop_front();
        total++;
        if ({aluResult_W, readData_W, misalign_W, bus_err_W} !== e) begin
            bad++; $display("FAIL timeout_wb: got alu=%h rd=%h mis=%b berr=%b want alu=%h rd=%h mis=%b berr=%b",
                            aluResult_W, readData_W, misalign_W, bus_err_W, e.alu, e.rd, e.mis, e.berr);
        end
        tick();
        tick();
        dm_ack = 1'b1; dm_rdata = 64'hCAFE;
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL late_ack_stall: got %b want 0", stall); end
        tick();
        dm_ack = 1'b0;
        total++;
        if (dm_req !== 1'b0 || out_valid !== 1'b0 || readData_W !== 64'h0) begin
            bad++; $display("FAIL late_ack: req=%b ov=%b rd=%h want 0 0 0", dm_req, out_valid, readData_W);
        end
    endtask

    task automatic test_branch();
        exp_t e;
        in_valid = 1'b1; Branch_M = 1'b1; zero_M = 1'b1; PCBranch_M = 64'h200; aluResult_M = 64'h0;
        sb.push_back('{alu: 64'h0, rd: 64'h0, mis: 1'b0, berr: 1'b0});
        #1;
        total++;
        if (PCSrc_M !== 1'b1 || PCBranch_out !== 64'h200) begin
            bad++; $display("FAIL branch_taken: pcsrc=%b tgt=%h want 1 200", PCSrc_M, PCBranch_out);
        end
        zero_M = 1'b0;
        #1;
        total++;
        if (PCSrc_M !== 1'b0) begin bad++; $display("FAIL branch_not_taken: pcsrc=%b want 0", PCSrc_M); end
        tick();
        clear_inputs();
        e = sb.pop_front();
        total++;
        if (out_valid !== 1'b1 || {aluResult_W, readData_W, misalign_W, bus_err_W} !== e) begin
            bad++; $display("FAIL branch_wb: ov=%b alu=%h rd=%h want ov=1 alu=%h rd=%h", out_valid, aluResult_W, readData_W, e.alu, e.rd);
        end
        tick();
    endtask

    task automatic test_reset_mid_access();
        exp_t e;
        in_valid = 1'b1; MemRead_M = 1'b1; aluResult_M = 64'h40;
        tick();
        total++;
        if (dm_req !== 1'b1) begin bad++; $display("FAIL midrst_req: req=%b want 1", dm_req); end
        Branch_M = 1'b1; zero_M = 1'b1;
        #1;
        total++;
        if (PCSrc_M !== 1'b0) begin bad++; $display("FAIL branch_in_access: pcsrc=%b want 0", PCSrc_M); end
        reset = 1'b0;
        #1;
        total++;
        if (dm_req !== 1'b0 || out_valid !== 1'b0 || dm_addr !== 64'h0) begin
            bad++; $display("FAIL midrst_async: req=%b ov=%b addr=%h want 0 0 0", dm_req, out_valid, dm_addr);
        end
        clear_inputs();
        @(negedge clk);
        reset = 1'b1;
        tick();
        in_valid = 1'b1; Branch_M = 1'b1; zero_M = 1'b1; PCBranch_M = 64'h300; aluResult_M = 64'h58;
        sb.push_back('{alu: 64'h58, rd: 64'h0, mis: 1'b0, berr: 1'b0});
        #1;
        total++;
        if (PCSrc_M !== 1'b1 || stall !== 1'b0) begin
            bad++; $display("FAIL midrst_idle: pcsrc=%b stall=%b want 1 0", PCSrc_M, stall);
        end
        tick();
        clear_inputs();
        e = sb.pop_front();
        total++;
        if (out_valid !== 1'b1 || {aluResult_W, readData_W, misalign_W, bus_err_W} !== e) begin
            bad++; $display("FAIL midrst_wb: ov=%b alu=%h want ov=1 alu=%h", out_valid, aluResult_W, e.alu);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [DW-1:0] addrs [4];
        logic [1:0]    ops   [4];   // {MemWrite, MemRead}
        addrs[0] = 64'h1000; ops[0] = 2'b00;
        addrs[1] = 64'h1001; ops[1] = 2'b10;
        addrs[2] = 64'h2222; ops[2] = 2'b00;
        addrs[3] = 64'h0007; ops[3] = 2'b11;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; MemWrite_M = ops[i][1]; MemRead_M = ops[i][0]; aluResult_M = addrs[i];
            sb.push_back('{alu: addrs[i], rd: 64'h0, mis: (ops[i] != 2'b00), berr: 1'b0});
            tick();
            e = sb.pop_front();
            total++;
            if (out_valid !== 1'b1 || dm_req !== 1'b0 || {aluResult_W, readData_W, misalign_W, bus_err_W} !== e) begin
                bad++; $display("FAIL b2b_%0d: ov=%b req=%b alu=%h mis=%b want ov=1 req=0 alu=%h mis=%b",
                                i, out_valid, dm_req, aluResult_W, misalign_W, e.alu, e.mis);
            end
        end
        clear_inputs();
        tick();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_end: ov=%b want 0", out_valid); end
    endtask

    initial begin
        reset = 1'b0; dm_ack = 1'b0; dm_rdata = 64'h0;
        clear_inputs();
        #12;
        test_reset();
        @(negedge clk);
        reset = 1'b1;
        tick();
        test_alu_only();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_branch();
        test_reset_mid_access();
        test_back_to_back();
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover: size=%0d want 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Stage directly downstream of execute in the 64-bit LEGv8 datapath.
- Consumes the ALU result, store data, zero flag and branch target, and resolves the branch (PCSrc).
- Performs data-memory loads and stores over a req/ack handshake to a variable-latency data memory, stalling upstream while an access is outstanding.
- Registers results toward writeback (MEM/WB boundary) and flags misaligned or timed-out accesses.

Parameters:
- DW, 64, data/address width.
- MAX_WAIT, 16, ack-wait cycles before the access is aborted with bus_err_W (range 1..255).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  execute outputs valid this cycle.
- MemRead_M  in  1  load.
- MemWrite_M  in  1  store.
- Branch_M  in  1  conditional branch.
- aluResult_M  in  DW  effective address / ALU result.
- writeData_M  in  DW  store data.
- zero_M  in  1  ALU zero flag.
- PCBranch_M  in  DW  branch target.
- stall  out  1  upstream holds all inputs while high.
- PCSrc_M  out  1  take branch.
- PCBranch_out  out  DW  PCBranch_M passthrough.
- dm_req  out  1  memory request.
- dm_we  out  1  1 = store.
- dm_addr  out  DW  request address.
- dm_wdata  out  DW  store data.
- dm_ack  in  1  memory completion, single-cycle pulse.
- dm_rdata  in  DW  load data, valid while dm_ack is high.
- out_valid  out  1  WB-side outputs valid.
- readData_W  out  DW  load result.
- aluResult_W  out  DW  registered ALU result.
- misalign_W  out  1  access skipped because address[2:0] != 0.
- bus_err_W  out  1  access aborted by timeout.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE, wait counter = 0.
  - dm_req, dm_we, out_valid, misalign_W, bus_err_W = 0.
  - dm_addr, dm_wdata, readData_W, aluResult_W = 0.
- FSM states: IDLE, ACCESS.
- memop = MemRead_M | MemWrite_M. If both are high, treat as a store.
- IDLE, in_valid=0:
  - out_valid=0 next cycle.
- IDLE, in_valid=1 and memop=0:
  - Next cycle: out_valid=1, aluResult_W=aluResult_M, readData_W=0, flags 0.
  - Latency 1, no stall.
- IDLE, in_valid=1, memop=1, aluResult_M[2:0] != 0:
  - No request issued.
  - Next cycle: out_valid=1, misalign_W=1, readData_W=0.
- IDLE, in_valid=1, memop=1, aligned:
  - stall=1 combinationally this cycle.
  - Next edge: dm_req=1, dm_we=MemWrite_M, dm_addr/dm_wdata latched, counter=0, state → ACCESS, out_valid=0.
- ACCESS:
  - dm_req, dm_addr, dm_wdata, dm_we held stable.
  - in_valid and all M inputs are ignored.
  - counter increments each cycle without ack.
  - stall = ~dm_ack & (counter != MAX_WAIT-1).
- ACCESS, dm_ack=1:
  - Next edge: dm_req=0, state → IDLE, out_valid=1, aluResult_W=latched address.
  - readData_W = dm_rdata for a load, 0 for a store.
- ACCESS, counter == MAX_WAIT-1 and dm_ack=0:
  - Next edge: dm_req=0, state → IDLE, out_valid=1, bus_err_W=1, readData_W=0.
- Access latency: out_valid rises one cycle after the ack or timeout cycle. Upstream advances on the same edge.
- Late ack (after abort, in IDLE): ignored.
- Branch resolution (combinational):
  - PCSrc_M = in_valid & Branch_M & zero_M & (state==IDLE).
  - PCBranch_out = PCBranch_M.
- out_valid is a one-cycle pulse per accepted instruction.
- Reset asserted mid-ACCESS: dm_req drops immediately (asynchronous); the access is discarded.

Decomposition:
- Package mem_pkg:
  - state enum {IDLE, ACCESS}.
  - ALIGN_MASK = 3'b111.
  - Width of the wait counter, $clog2(MAX_WAIT+1).
- Sub-module mem_wait_timer: counter with clear, enable and expire output.
- FSM, request registers and WB registers live in memory_stage.

Test Plan:
- ALU-only op, aluResult_M=0x40, memop=0 → next cycle out_valid=1, aluResult_W=0x40, stall never high.
- Load at 0x100 with ack after 3 cycles, dm_rdata=0xDEADBEEF → dm_req high for 3 cycles at addr 0x100, stall high until the ack cycle, then out_valid=1, readData_W=0xDEADBEEF.
- Store at 0x8, writeData_M=0x1234, immediate ack → dm_we=1, dm_wdata=0x1234, readData_W=0, out_valid one cycle after the ack.
- Load at 0x103 → dm_req stays 0; next cycle out_valid=1, misalign_W=1.
- Load with no ack, MAX_WAIT=16 → dm_req high for exactly 16 cycles, then out_valid=1, bus_err_W=1; an ack 2 cycles later is ignored.
- Branch_M=1, zero_M=1, in_valid=1, PCBranch_M=0x200 → PCSrc_M=1 and PCBranch_out=0x200 same cycle; reset low mid-ACCESS → dm_req=0 immediately, state IDLE.
